// File: rtl/reg_file_mp_if.sv
// Port bundle for reg_file_mp: writeback and load-return writes, reservations,
// operand reads and the busy/pending status returned to decode.
interface reg_file_mp_if #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned REG_COUNT  = 32,
    parameter int unsigned READ_PORTS = 2
);
    localparam int unsigned AW = $clog2(REG_COUNT);

    logic                         wb_en_i;
    logic [AW-1:0]                wb_addr_i;
    logic [WIDTH-1:0]             wb_data_i;
    logic                         ld_en_i;
    logic [AW-1:0]                ld_addr_i;
    logic [WIDTH-1:0]             ld_data_i;
    logic                         rsv_en_i;
    logic [AW-1:0]                rsv_addr_i;
    logic [READ_PORTS*AW-1:0]     rd_addr_i;
    logic [READ_PORTS*WIDTH-1:0]  rd_data_o;
    logic [READ_PORTS-1:0]        rd_busy_o;
    logic                         rsv_conflict_o;
    logic                         pending_any_o;

    modport master (
        output wb_en_i, wb_addr_i, wb_data_i,
        output ld_en_i, ld_addr_i, ld_data_i,
        output rsv_en_i, rsv_addr_i, rd_addr_i,
        input  rd_data_o, rd_busy_o, rsv_conflict_o, pending_any_o
    );

    modport slave (
        input  wb_en_i, wb_addr_i, wb_data_i,
        input  ld_en_i, ld_addr_i, ld_data_i,
        input  rsv_en_i, rsv_addr_i, rd_addr_i,
        output rd_data_o, rd_busy_o, rsv_conflict_o, pending_any_o
    );
endinterface

// File: rtl/reg_file_mp.sv
// Multi-port register file with writeback and load-return write ports, optional
// write-to-read bypass and a per-register pending-load scoreboard.
module reg_file_mp #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned REG_COUNT  = 32,
    parameter int unsigned READ_PORTS = 2,
    parameter bit          ZERO_REG   = 1'b1,
    parameter bit          BYPASS     = 1'b1
) (
    input logic          clk,
    input logic          rst,
    reg_file_mp_if.slave bus
);
    localparam int unsigned AW = $clog2(REG_COUNT);

    logic [WIDTH-1:0]            mem_q [REG_COUNT];
    logic [WIDTH-1:0]            mem_d [REG_COUNT];
    logic [REG_COUNT-1:0]        pend_q;
    logic [REG_COUNT-1:0]        pend_d;
    logic                        wb_ok;
    logic                        ld_ok;
    logic                        rsv_ok;
    logic [AW-1:0]               ra;
    logic [READ_PORTS*WIDTH-1:0] rd_data;
    logic [READ_PORTS-1:0]       rd_busy;

    // Writable: in range and not the hardwired zero register.
    function automatic logic writable(input logic [AW-1:0] a);
        return (32'(a) < REG_COUNT) && !(ZERO_REG && (a == '0));
    endfunction

    assign wb_ok  = bus.wb_en_i  & writable(bus.wb_addr_i);
    assign ld_ok  = bus.ld_en_i  & writable(bus.ld_addr_i);
    assign rsv_ok = bus.rsv_en_i & writable(bus.rsv_addr_i);

    // wb is applied after ld so it wins a same-address collision; reserve is
    // applied after the load clear so back-to-back loads keep the bit set.
    always_comb begin
        mem_d  = mem_q;
        pend_d = pend_q;
        if (ld_ok)  mem_d[bus.ld_addr_i]   = bus.ld_data_i;
        if (wb_ok)  mem_d[bus.wb_addr_i]   = bus.wb_data_i;
        if (ld_ok)  pend_d[bus.ld_addr_i]  = 1'b0;
        if (rsv_ok) pend_d[bus.rsv_addr_i] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < REG_COUNT; i++) begin
                mem_q[i] <= '0;
            end
            pend_q <= '0;
        end else begin
            mem_q  <= mem_d;
            pend_q <= pend_d;
        end
    end

    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        ra      = '0;
        for (int unsigned k = 0; k < READ_PORTS; k++) begin
            ra = bus.rd_addr_i[k*AW +: AW];
            if (32'(ra) < REG_COUNT) begin
                rd_data[k*WIDTH +: WIDTH] = mem_q[ra];
                rd_busy[k]                = pend_q[ra];
            end
            if (BYPASS) begin
                if (ld_ok && (bus.ld_addr_i == ra)) rd_data[k*WIDTH +: WIDTH] = bus.ld_data_i;
                if (wb_ok && (bus.wb_addr_i == ra)) rd_data[k*WIDTH +: WIDTH] = bus.wb_data_i;
                if (bus.ld_en_i && (bus.ld_addr_i == ra)) rd_busy[k] = 1'b0;
            end
            if (ZERO_REG && (ra == '0)) begin
                rd_data[k*WIDTH +: WIDTH] = '0;
                rd_busy[k]                = 1'b0;
            end
        end
    end

    assign bus.rd_data_o      = rd_data;
    assign bus.rd_busy_o      = rd_busy;
    assign bus.rsv_conflict_o = bus.rsv_en_i & pend_q[bus.rsv_addr_i]
                              & ~(bus.ld_en_i & (bus.ld_addr_i == bus.rsv_addr_i));
    assign bus.pending_any_o  = |pend_q;
endmodule

// File: tb/tb_reg_file_mp.sv
// Bench for reg_file_mp: one bypassing and one non-bypassing instance driven with
// identical stimulus, expectations queued per cycle and compared mid-cycle.
module tb_reg_file_mp;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    reg_file_mp_if #(.WIDTH(32), .REG_COUNT(32), .READ_PORTS(2)) bus_b ();
    reg_file_mp_if #(.WIDTH(32), .REG_COUNT(32), .READ_PORTS(2)) bus_n ();

    reg_file_mp #(.BYPASS(1'b1)) u_byp (.clk(clk), .rst(rst), .bus(bus_b.slave));
    reg_file_mp #(.BYPASS(1'b0)) u_nob (.clk(clk), .rst(rst), .bus(bus_n.slave));

    assign bus_n.wb_en_i    = bus_b.wb_en_i;
    assign bus_n.wb_addr_i  = bus_b.wb_addr_i;
    assign bus_n.wb_data_i  = bus_b.wb_data_i;
    assign bus_n.ld_en_i    = bus_b.ld_en_i;
    assign bus_n.ld_addr_i  = bus_b.ld_addr_i;
    assign bus_n.ld_data_i  = bus_b.ld_data_i;
    assign bus_n.rsv_en_i   = bus_b.rsv_en_i;
    assign bus_n.rsv_addr_i = bus_b.rsv_addr_i;
    assign bus_n.rd_addr_i  = bus_b.rd_addr_i;

    // Inputs, then expected outputs (b = BYPASS=1 instance, n = BYPASS=0 instance).
    typedef struct {
        logic        wb_en;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        le;
        logic [4:0]  la;
        logic [31:0] ldd;
        logic        re;
        logic [4:0]  rsa;
        logic [4:0]  a0;
        logic [4:0]  a1;
        logic [31:0] d0b;
        logic [31:0] d1b;
        logic [31:0] d0n;
        logic [31:0] d1n;
        logic [1:0]  bb;
        logic [1:0]  bn;
        logic        conf;
        logic        pa;
    } vec_t;

    vec_t tbl [22];
    vec_t sb [$];
    int   id_q [$];
    int   nvec   = 0;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input int id, input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL vec%0d %s got %h expected %h", id, nm, act, exp);
        end
    endtask

    task automatic check_out();
        vec_t e;
        int   id;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard got empty expected entry");
            return;
        end
        e  = sb.pop_front();
        id = id_q.pop_front();
        chk(id, "d0_byp",   bus_b.rd_data_o[31:0],  e.d0b);
        chk(id, "d1_byp",   bus_b.rd_data_o[63:32], e.d1b);
        chk(id, "d0_nob",   bus_n.rd_data_o[31:0],  e.d0n);
        chk(id, "d1_nob",   bus_n.rd_data_o[63:32], e.d1n);
        chk(id, "busy_byp", 32'(bus_b.rd_busy_o),   32'(e.bb));
        chk(id, "busy_nob", 32'(bus_n.rd_busy_o),   32'(e.bn));
        chk(id, "conf_byp", 32'(bus_b.rsv_conflict_o), 32'(e.conf));
        chk(id, "conf_nob", 32'(bus_n.rsv_conflict_o), 32'(e.conf));
        chk(id, "pa_byp",   32'(bus_b.pending_any_o),  32'(e.pa));
        chk(id, "pa_nob",   32'(bus_n.pending_any_o),  32'(e.pa));
    endtask

    task automatic run_vec(input vec_t v);
        bus_b.wb_en_i    = v.wb_en;
        bus_b.wb_addr_i  = v.wa;
        bus_b.wb_data_i  = v.wd;
        bus_b.ld_en_i    = v.le;
        bus_b.ld_addr_i  = v.la;
        bus_b.ld_data_i  = v.ldd;
        bus_b.rsv_en_i   = v.re;
        bus_b.rsv_addr_i = v.rsa;
        bus_b.rd_addr_i  = {v.a1, v.a0};
        sb.push_back(v);
        id_q.push_back(nvec);
        nvec++;
        @(negedge clk);
        check_out();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Zero register via both ports plus reservation.
        tbl[0]  = '{1, 0, 32'h1234, 1, 0, 32'h1234, 1, 0, 0, 0,
                    32'h0, 32'h0, 32'h0, 32'h0, 2'b00, 2'b00, 0, 0};
        tbl[1]  = '{0, 0, 32'h0, 0, 0, 32'h0, 0, 0, 0, 7,
                    32'h0, 32'h0, 32'h0, 32'h0, 2'b00, 2'b00, 0, 0};
        // Dual-write collision on r7: writeback wins.
        tbl[2]  = '{1, 7, 32'hAAAA0001, 1, 7, 32'hBBBB0002, 0, 0, 7, 0,
                    32'hAAAA0001, 32'h0, 32'h0, 32'h0, 2'b00, 2'b00, 0, 0};
        tbl[3]  = '{0, 0, 32'h0, 0, 0, 32'h0, 0, 0, 7, 0,
                    32'hAAAA0001, 32'h0, 32'hAAAA0001, 32'h0, 2'b00, 2'b00, 0, 0};
        // r3 = 0x11, then overwrite with 0x55.
        tbl[4]  = '{1, 3, 32'h11, 0, 0, 32'h0, 0, 0, 3, 7,
                    32'h11, 32'hAAAA0001, 32'h0, 32'hAAAA0001, 2'b00, 2'b00, 0, 0};
        tbl[5]  = '{1, 3, 32'h55, 0, 0, 32'h0, 0, 0, 3, 7,
                    32'h55, 32'hAAAA0001, 32'h11, 32'hAAAA0001, 2'b00, 2'b00, 0, 0};
        tbl[6]  = '{0, 0, 32'h0, 0, 0, 32'h0, 0, 0, 3, 7,
                    32'h55, 32'hAAAA0001, 32'h55, 32'hAAAA0001, 2'b00, 2'b00, 0, 0};
        // Scoreboard lifecycle on r9 (holds 0x77 from the reset sequence).
        tbl[7]  = '{0, 0, 32'h0, 0, 0, 32'h0, 1, 9, 9, 3,
                    32'h77, 32'h55, 32'h77, 32'h55, 2'b00, 2'b00, 0, 0};
        tbl[8]  = '{0, 0, 32'h0, 0, 0, 32'h0, 0, 0, 9, 3,
                    32'h77, 32'h55, 32'h77, 32'h55, 2'b01, 2'b01, 0, 1};
        tbl[9]  = '{0, 0, 32'h0, 0, 0, 32'h0, 0, 0, 9, 3,
                    32'h77, 32'h55, 32'h77, 32'h55, 2'b01, 2'b01, 0, 1};
        tbl[10] = '{0, 0, 32'h0, 1, 9, 32'hCAFE, 0, 0, 9, 3,
                    32'hCAFE, 32'h55, 32'h77, 32'h55, 2'b00, 2'b01, 0, 1};
        tbl[11] = '{0, 0, 32'h0, 0, 0, 32'h0, 0, 0, 9, 3,
                    32'hCAFE, 32'h55, 32'hCAFE, 32'h55, 2'b00, 2'b00, 0, 0};
        // Reserve vs return race on r4, then a genuine conflict.
        tbl[12] = '{0, 0, 32'h0, 0, 0, 32'h0, 1, 4, 4, 9,
                    32'h0, 32'hCAFE, 32'h0, 32'hCAFE, 2'b00, 2'b00, 0, 0};
        tbl[13] = '{0, 0, 32'h0, 0, 0, 32'h0, 0, 0, 4, 9,
                    32'h0, 32'hCAFE, 32'h0, 32'hCAFE, 2'b01, 2'b01, 0, 1};
        tbl[14] = '{0, 0, 32'h0, 1, 4, 32'h44, 1, 4, 4, 9,
                    32'h44, 32'hCAFE, 32'h0, 32'hCAFE, 2'b00, 2'b01, 0, 1};
        tbl[15] = '{0, 0, 32'h0, 0, 0, 32'h0, 0, 0, 4, 9,
                    32'h44, 32'hCAFE, 32'h44, 32'hCAFE, 2'b01, 2'b01, 0, 1};
        tbl[16] = '{0, 0, 32'h0, 0, 0, 32'h0, 1, 4, 4, 9,
                    32'h44, 32'hCAFE, 32'h44, 32'hCAFE, 2'b01, 2'b01, 1, 1};
        tbl[17] = '{0, 0, 32'h0, 0, 0, 32'h0, 0, 0, 4, 9,
                    32'h44, 32'hCAFE, 32'h44, 32'hCAFE, 2'b01, 2'b01, 0, 1};
        // Collision while r4 pending: wb data wins, ld still clears pending.
        tbl[18] = '{1, 4, 32'h46, 1, 4, 32'h45, 0, 0, 4, 4,
                    32'h46, 32'h46, 32'h44, 32'h44, 2'b00, 2'b11, 0, 1};
        tbl[19] = '{0, 0, 32'h0, 0, 0, 32'h0, 0, 0, 4, 4,
                    32'h46, 32'h46, 32'h46, 32'h46, 2'b00, 2'b00, 0, 0};
        // Top register on read port 1.
        tbl[20] = '{1, 31, 32'hFFFFFFFF, 0, 0, 32'h0, 0, 0, 0, 31,
                    32'h0, 32'hFFFFFFFF, 32'h0, 32'h0, 2'b00, 2'b00, 0, 0};
        tbl[21] = '{0, 0, 32'h0, 0, 0, 32'h0, 0, 0, 0, 31,
                    32'h0, 32'hFFFFFFFF, 32'h0, 32'hFFFFFFFF, 2'b00, 2'b00, 0, 0};

        bus_b.wb_en_i    = 1'b0;
        bus_b.wb_addr_i  = '0;
        bus_b.wb_data_i  = '0;
        bus_b.ld_en_i    = 1'b0;
        bus_b.ld_addr_i  = '0;
        bus_b.ld_data_i  = '0;
        bus_b.rsv_en_i   = 1'b0;
        bus_b.rsv_addr_i = '0;
        bus_b.rd_addr_i  = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state, then write/reserve, then a reset that overrides writes.
        run_vec('{0, 0, 32'h0, 0, 0, 32'h0, 0, 0, 5, 9,
                  32'h0, 32'h0, 32'h0, 32'h0, 2'b00, 2'b00, 0, 0});
        run_vec('{1, 5, 32'hDEADBEEF, 0, 0, 32'h0, 1, 9, 5, 9,
                  32'hDEADBEEF, 32'h0, 32'h0, 32'h0, 2'b00, 2'b00, 0, 0});
        run_vec('{0, 0, 32'h0, 0, 0, 32'h0, 0, 0, 5, 9,
                  32'hDEADBEEF, 32'h0, 32'hDEADBEEF, 32'h0, 2'b10, 2'b10, 0, 1});
        rst = 1'b1;
        run_vec('{1, 5, 32'h99, 0, 0, 32'h0, 1, 3, 5, 9,
                  32'h99, 32'h0, 32'hDEADBEEF, 32'h0, 2'b10, 2'b10, 0, 1});
        rst = 1'b0;
        // Load return after reset discarded the reservation: plain write.
        run_vec('{0, 0, 32'h0, 1, 9, 32'h77, 0, 0, 5, 9,
                  32'h0, 32'h77, 32'h0, 32'h0, 2'b00, 2'b00, 0, 0});
        run_vec('{0, 0, 32'h0, 0, 0, 32'h0, 0, 0, 3, 9,
                  32'h0, 32'h77, 32'h0, 32'h77, 2'b00, 2'b00, 0, 0});

        for (int i = 0; i < 22; i++) begin
            run_vec(tbl[i]);
        end

        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_leftover got %0d expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/reg_file_mp.md
# reg_file_mp

Parametrised general-purpose register file, the next generation of the core's register file. It is generalised in data width, register count and read-port count. It adds two write ports: writeback, and late load return. It also provides optional write-to-read bypass and a per-register pending-write scoreboard for long-latency loads. It sits in the decode/writeback boundary of the pipeline: decode reads operands and busy flags, writeback and the load unit write results.

## Interface
- `WIDTH`, 32, data width of each register.
- `REG_COUNT`, 32, number of registers; address width `AW = $clog2(REG_COUNT)`.
- `READ_PORTS`, 2, number of independent combinational read ports.
- `ZERO_REG`, 1, when 1 register 0 reads as 0 and ignores writes/reservations.
- `BYPASS`, 1, when 1 same-cycle write data is forwarded to matching reads.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `wb_en_i`  in  1  writeback port write enable.
- `wb_addr_i`  in  AW  writeback destination.
- `wb_data_i`  in  WIDTH  writeback data.
- `ld_en_i`  in  1  load-return port write enable.
- `ld_addr_i`  in  AW  load-return destination.
- `ld_data_i`  in  WIDTH  load-return data.
- `rsv_en_i`  in  1  reserve request: mark `rsv_addr_i` as pending a load.
- `rsv_addr_i`  in  AW  register to reserve.
- `rd_addr_i`  in  READ_PORTS*AW  read addresses, port k at bits [k*AW +: AW].
- `rd_data_o`  out  READ_PORTS*WIDTH  read data, port k at [k*WIDTH +: WIDTH].
- `rd_busy_o`  out  READ_PORTS  port k's register has an outstanding load.
- `rsv_conflict_o`  out  1  reserve request targets an already-pending register.
- `pending_any_o`  out  1  OR of all pending bits.

## Operation
- **State:** `REG_COUNT` x `WIDTH` data array plus `REG_COUNT` pending bits.
- **Reset:** on a rising edge with `rst`=1, all registers become 0 and all pending bits are cleared.
  - Reset overrides every write and reservation in that cycle.
  - Reset asserted mid-load discards the reservation; a later `ld_en_i` for that register simply writes data.
- **Writes:** both ports commit at the same edge.
  - If both ports target the same address, the writeback port wins.
  - With `ZERO_REG`=1, writes to address 0 are dropped.
- **Reads:** purely combinational.
  - With `ZERO_REG`=1, address 0 returns 0 regardless of the array contents.
  - With `BYPASS`=1, a read whose address matches an enabled write this cycle returns the incoming data, using the same priority (wb over ld).
  - With `BYPASS`=0, reads return the stored value only.
- **Scoreboard:**
  - `rsv_en_i` sets `pending[rsv_addr_i]` at the edge.
  - `ld_en_i` clears `pending[ld_addr_i]`.
  - The writeback port never alters pending bits.
  - Reserve and load-return to the same address in one cycle: the reserve wins and the bit stays 1 (back-to-back loads).
  - Reserve of register 0 is ignored when `ZERO_REG`=1.
- **Busy flag:** `rd_busy_o[k] = pending[a_k] & ~(BYPASS & ld_en_i & ld_addr_i==a_k)`, where `a_k` is port k's read address. It is always 0 for address 0 when `ZERO_REG`=1.
- **Conflict flag:** `rsv_conflict_o = rsv_en_i & pending[rsv_addr_i] & ~(ld_en_i & ld_addr_i==rsv_addr_i)`. This flag is informational only; the reservation is still applied, which leaves the bit set.
- **Pending summary:** `pending_any_o` reflects the registered pending bits only, with no combinational terms.

## Timing
- Read latency: 0 cycles (address to data, combinational).
- Write visibility: the same cycle with `BYPASS`=1; the cycle after the edge with `BYPASS`=0.
- Reserve visibility: `rd_busy_o` and `pending_any_o` rise the cycle after the `rsv_en_i` edge.
- Load-return visibility:
  - `rd_busy_o` falls in the same cycle as `ld_en_i` when `BYPASS`=1, otherwise the next cycle.
  - `pending_any_o` falls the cycle after.
- Output reset values, evaluated after the reset edge with inputs idle:
  - `rd_data_o` = 0.
  - `rd_busy_o` = 0.
  - `rsv_conflict_o` = 0.
  - `pending_any_o` = 0.
- No handshakes and no stalls; the block never refuses a write.

## Test plan
- **Reset:** write 0xDEADBEEF to r5, then assert `rst` for one edge. Required: read r5 = 0 and `pending_any_o` = 0.
- **Zero register:** write 0x1234 to r0 via both ports, and reserve r0. Required: r0 reads 0, `rd_busy_o` = 0, `pending_any_o` stays 0.
- **Dual-write collision:** wb writes 0xAAAA_0001 and ld writes 0xBBBB_0002, both to r7, in the same cycle.
  - Required, same cycle (`BYPASS`=1): read r7 = 0xAAAA_0001.
  - Required, next cycle (`BYPASS`=1 and 0): read r7 = 0xAAAA_0001.
- **Bypass off:** with `BYPASS`=0, write 0x55 to r3 at cycle N while reading r3 (previously 0x11). Required: read 0x11 in cycle N and 0x55 in cycle N+1.
- **Scoreboard lifecycle:** reserve r9 at cycle 0.
  - Cycle 1: `rd_busy_o`=1 and `pending_any_o`=1.
  - Cycle 3, `ld_en_i` with r9 and 0xCAFE: `rd_busy_o`=0 and data 0xCAFE (`BYPASS`=1).
  - Cycle 4: `pending_any_o`=0.
- **Reserve vs return race:** with r4 pending, reserve r4 and return a load to r4 in the same cycle. Required: `rsv_conflict_o`=0, r4 still busy the next cycle. Then a second reserve of r4 with no return gives `rsv_conflict_o`=1.
